fcounter_seq: RTL and testbench
===============================

Name: fcounter_seq

Overview:
Measurement sequencer that drives the fcounter control handshake (fcounter_ce / fcounter_som in, fcounter_eom / fcounter_rdy / fcounter_adata out of fcounter). On a single start request it arms fcounter, times a programmable gate window in clk cycles, stops the measurement, captures adata and compares it against a low/high window. It sits between the trim/calibration logic and an fcounter instance, in the clk domain.

Parameters:
N, 8, width of fcounter_adata, lo_limit, hi_limit and result
W, 12, width of window_len, the gate window length in clk cycles
TMO_W, 10, width of the eom watchdog counter (used only with the optional feature)

Ports:
clk  input  1  system clock, same clock as fcounter
rstb  input  1  asynchronous active-low reset
start  input  1  1-cycle request, sampled only in IDLE
window_len  input  W  gate length in clk cycles, sampled on accepted start; 0 is treated as 1
lo_limit  input  N  inclusive lower bound, sampled on accepted start
hi_limit  input  N  inclusive upper bound, sampled on accepted start
busy  output  1  high from the cycle after start acceptance until done
done  output  1  1-cycle pulse when result and in_range are valid
result  output  N  captured fcounter_adata, held until the next capture
in_range  output  1  lo_limit <= result <= hi_limit, unsigned
fcounter_ce  output  1  chip-enable pulse to fcounter, always exactly 1 clk wide
fcounter_som  output  1  start-of-measurement level to fcounter
fcounter_eom  input  1  end-of-measurement from fcounter, synchronous to clk
fcounter_rdy  input  1  fcounter ready, synchronous to clk
fcounter_adata  input  N  measurement result from fcounter
timeout  output  1  sticky watchdog flag (optional feature only, otherwise tied 0)

Behaviour:
- Clock and reset: one clock, clk. Reset rstb is asynchronous and active-low. The reset value of every output and register is 0. FSM resets to IDLE.
- FSM states and transitions:
  IDLE: start && fcounter_rdy -> ARM. start is ignored while fcounter_rdy = 0 or FSM is not in IDLE.
  ARM: som = 1 and ce = 1 for one cycle -> WAIT_LOW.
  WAIT_LOW: som held at 1. When eom = 0 -> WINDOW, and som falls on that same transition.
  WINDOW: down-counter loaded with window_len - 1 counts to 0 -> STOP.
  STOP: ce = 1 for one cycle -> WAIT_EOM.
  WAIT_EOM: on eom rising (eom = 1 and previous eom = 0) -> CAPTURE.
  CAPTURE: result <= adata, in_range updated -> RELEASE.
  RELEASE: ce = 1 for one cycle, done = 1 on the same cycle -> IDLE.
- Latency: a window_len of L gives exactly L clk cycles between the falling edge of som and the stop ce pulse.
- ce pulses never occur back-to-back. Minimum ce low time is 1 cycle.
- Limit comparison uses unsigned N-bit values. If lo_limit > hi_limit, in_range = 0.
- An eom that is already high when WAIT_EOM is entered does not count as a rising edge. The edge detector is re-armed on STOP.
- Reset mid-operation: som and ce go to 0 immediately and the FSM returns to IDLE. result is cleared.
- busy = 1 in every state except IDLE.

Optional Feature:
FCOUNTER_SEQ_TIMEOUT_EN
- Defined: a TMO_W-bit counter runs in WAIT_LOW and in WAIT_EOM. When it saturates at all ones, the FSM goes to RELEASE without capturing; result keeps its old value, in_range = 0, and timeout is set. timeout clears on the next accepted start.
- Undefined: there is no counter, those states wait indefinitely, and the timeout port is tied to 0.

Decomposition:
- Package fcounter_pkg holds the FSM state enum (IDLE, ARM, WAIT_LOW, WINDOW, STOP, WAIT_EOM, CAPTURE, RELEASE) and the default widths.
- One sub-module, fcounter_seq_timer: a loadable down-counter with a terminal-count flag, reused for the gate window and the watchdog.

Test Plan:
1. fcounter instance, clk 31 ns, ms_clk 100 ns, ref_clk = clk, window_len = 323, limits 99/101 -> som/ce sequence matches the protocol; result within 99..101, in_range = 1, one done pulse.
2. Same setup with ms_clk / 2, limits 99/101 -> result within 49..51, in_range = 0. Then limits 49/51 -> in_range = 1.
3. start held high for 5 cycles, and start pulsed while busy -> exactly one measurement and one done pulse.
4. rstb asserted during WINDOW -> som, ce, busy and result are 0 in the same time step. A new start then completes normally.
5. window_len = 0 and window_len = 1 -> both give a 1-cycle gate. fcounter_rdy = 0 at start -> request ignored, busy stays 0.
6. With FCOUNTER_SEQ_TIMEOUT_EN defined and eom stuck at 0 -> timeout = 1 after 2^TMO_W - 1 cycles in WAIT_EOM, done pulses, result unchanged.

Source files
------------

// File: rtl/fcounter_pkg.sv
// Shared FSM state encoding and default widths for the fcounter measurement sequencer.
package fcounter_pkg;
  localparam int N_DEF     = 8;
  localparam int W_DEF     = 12;
  localparam int TMO_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_LOW,
    WINDOW,
    STOP,
    WAIT_EOM,
    CAPTURE,
    RELEASE
  } state_t;
endpackage

// File: rtl/fcounter_seq_timer.sv
// Loadable down-counter that holds at zero; tc is high while the count is zero.
// Loading V and enabling every cycle gives tc after exactly V enabled cycles.
module fcounter_seq_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/fcounter_seq.sv
// Sequences one fcounter measurement per accepted start: arm, gate window, stop, capture, limit check.
// Optional eom watchdog with sticky timeout flag under FCOUNTER_SEQ_TIMEOUT_EN.
module fcounter_seq
  import fcounter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
`ifdef FCOUNTER_SEQ_TIMEOUT_EN
  , parameter int TMO_W = TMO_W_DEF
`endif
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         start,
  input  logic [W-1:0] window_len,
  input  logic [N-1:0] lo_limit,
  input  logic [N-1:0] hi_limit,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         in_range,
  output logic         fcounter_ce,
  output logic         fcounter_som,
  input  logic         fcounter_eom,
  input  logic         fcounter_rdy,
  input  logic [N-1:0] fcounter_adata,
  output logic         timeout
);
  state_t       state;
  logic [W-1:0] wlen_q;
  logic [N-1:0] lo_q;
  logic [N-1:0] hi_q;
  logic         eom_q;
  logic         win_tc;
  logic [W-1:0] win_load;

  // A zero length gate behaves like a one cycle gate.
  assign win_load = (wlen_q == '0) ? '0 : wlen_q - W'(1);

  fcounter_seq_timer #(.WIDTH(W)) u_win (
    .clk      (clk),
    .rstb     (rstb),
    .load     ((state == WAIT_LOW) && !fcounter_eom),
    .load_val (win_load),
    .en       (state == WINDOW),
    .tc       (win_tc)
  );

`ifdef FCOUNTER_SEQ_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LOAD = {{(TMO_W-1){1'b1}}, 1'b0};
  logic wd_tc;
  logic tmo_flag;

  // Reloaded on entry to each wait state so both waits get the full budget.
  fcounter_seq_timer #(.WIDTH(TMO_W)) u_wd (
    .clk      (clk),
    .rstb     (rstb),
    .load     ((state == ARM) || (state == STOP)),
    .load_val (TMO_LOAD),
    .en       ((state == WAIT_LOW) || (state == WAIT_EOM)),
    .tc       (wd_tc)
  );
  assign timeout = tmo_flag;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      fcounter_som <= 1'b0;
      fcounter_ce  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      in_range     <= 1'b0;
      wlen_q       <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      eom_q        <= 1'b0;
`ifdef FCOUNTER_SEQ_TIMEOUT_EN
      tmo_flag     <= 1'b0;
`endif
    end else begin
      // eom sampled during STOP means a stale high eom is not seen as an edge.
      eom_q       <= fcounter_eom;
      fcounter_ce <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && fcounter_rdy) begin
            wlen_q       <= window_len;
            lo_q         <= lo_limit;
            hi_q         <= hi_limit;
            fcounter_som <= 1'b1;
            fcounter_ce  <= 1'b1;
            busy         <= 1'b1;
`ifdef FCOUNTER_SEQ_TIMEOUT_EN
            tmo_flag     <= 1'b0;
`endif
            state        <= ARM;
          end
        end
        ARM: state <= WAIT_LOW;
        WAIT_LOW: begin
          if (!fcounter_eom) begin
            fcounter_som <= 1'b0;
            state        <= WINDOW;
          end
`ifdef FCOUNTER_SEQ_TIMEOUT_EN
          else if (wd_tc) begin
            fcounter_som <= 1'b0;
            fcounter_ce  <= 1'b1;
            done         <= 1'b1;
            in_range     <= 1'b0;
            tmo_flag     <= 1'b1;
            state        <= RELEASE;
          end
`endif
        end
        WINDOW: begin
          if (win_tc) begin
            fcounter_ce <= 1'b1;
            state       <= STOP;
          end
        end
        STOP: state <= WAIT_EOM;
        WAIT_EOM: begin
          if (fcounter_eom && !eom_q) begin
            state <= CAPTURE;
          end
`ifdef FCOUNTER_SEQ_TIMEOUT_EN
          else if (wd_tc) begin
            fcounter_ce <= 1'b1;
            done        <= 1'b1;
            in_range    <= 1'b0;
            tmo_flag    <= 1'b1;
            state       <= RELEASE;
          end
`endif
        end
        CAPTURE: begin
          result      <= fcounter_adata;
          in_range    <= (lo_q <= fcounter_adata) && (fcounter_adata <= hi_q);
          fcounter_ce <= 1'b1;
          done        <= 1'b1;
          state       <= RELEASE;
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fcounter_seq.sv
// Directed bench for fcounter_seq; the bench plays the fcounter side of the handshake.
module tb_fcounter_seq;
  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        start = 1'b0;
  logic [11:0] window_len = '0;
  logic [7:0]  lo_limit = '0;
  logic [7:0]  hi_limit = '0;
  logic        busy, done, in_range, fcounter_ce, fcounter_som, timeout;
  logic [7:0]  result;
  logic        fcounter_eom = 1'b1;
  logic        fcounter_rdy = 1'b1;
  logic [7:0]  fcounter_adata = '0;

  int total = 0;
  int bad = 0;
  int ce_cnt = 0;
  int done_cnt = 0;
  int b2b = 0;
  logic ce_prev = 1'b0;

  fcounter_seq dut (
    .clk(clk), .rstb(rstb), .start(start), .window_len(window_len),
    .lo_limit(lo_limit), .hi_limit(hi_limit), .busy(busy), .done(done),
    .result(result), .in_range(in_range), .fcounter_ce(fcounter_ce),
    .fcounter_som(fcounter_som), .fcounter_eom(fcounter_eom),
    .fcounter_rdy(fcounter_rdy), .fcounter_adata(fcounter_adata), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (fcounter_ce && ce_prev) b2b++;
    ce_prev = fcounter_ce;
    ce_cnt += int'(fcounter_ce);
    done_cnt += int'(done);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_meas(input string tag, input logic [11:0] wl, input logic [7:0] lo,
                         input logic [7:0] hi, input logic [7:0] ad, input logic exp_inr,
                         input int exp_gate, input int hold, input logic poke);
    int n;
    window_len = wl; lo_limit = lo; hi_limit = hi;
    fcounter_eom = 1'b1; fcounter_rdy = 1'b1;
    start = 1'b1;
    tick();
    chk({tag, "_arm"}, {29'd0, busy, fcounter_som, fcounter_ce}, 32'd7);
    for (int i = 1; i < hold; i++) tick();
    start = 1'b0;
    // Inputs must have been captured at acceptance.
    window_len = '0; lo_limit = 8'hA5; hi_limit = 8'h5A;
    tick();
    chk({tag, "_wlow"}, {29'd0, busy, fcounter_som, fcounter_ce}, 32'd6);
    fcounter_eom = 1'b0;
    tick();
    chk({tag, "_win"}, {29'd0, busy, fcounter_som, fcounter_ce}, 32'd4);
    start = poke;
    n = 0;
    while (!fcounter_ce && n < 5000) begin
      tick();
      n++;
    end
    start = 1'b0;
    chk({tag, "_gate"}, n, exp_gate);
    fcounter_adata = ad;
    fcounter_eom = 1'b1;
    tick();
    tick();
    tick();
    chk({tag, "_stale"}, {30'd0, done, fcounter_ce}, 32'd0);
    fcounter_eom = 1'b0;
    tick();
    fcounter_eom = 1'b1;
    tick();
    chk({tag, "_cap"}, {30'd0, done, fcounter_ce}, 32'd0);
    tick();
    chk({tag, "_rel"}, {29'd0, done, fcounter_ce, busy}, 32'd7);
    chk({tag, "_res"}, result, ad);
    chk({tag, "_inr"}, in_range, exp_inr);
    tick();
    chk({tag, "_idle"}, {29'd0, done, fcounter_ce, busy}, 32'd0);
    chk({tag, "_tmo"}, timeout, 1'b0);
  endtask

  initial begin
    int c0, d0, n;
    #1 rstb = 1'b0;
    #2;
    chk("rst_ctl", {27'd0, busy, done, in_range, fcounter_ce, fcounter_som}, 32'd0);
    chk("rst_res", result, 8'd0);
    chk("rst_tmo", timeout, 1'b0);
    #10 rstb = 1'b1;
    tick();

    do_meas("m1",   12'd323, 8'd99,  8'd101, 8'd100, 1'b1, 323,  1, 1'b0);
    do_meas("m2",   12'd323, 8'd99,  8'd101, 8'd50,  1'b0, 323,  1, 1'b0);
    do_meas("m3",   12'd10,  8'd49,  8'd51,  8'd50,  1'b1, 10,   1, 1'b0);
    do_meas("lohi", 12'd2,   8'd60,  8'd40,  8'd50,  1'b0, 2,    1, 1'b0);
    do_meas("w0",   12'd0,   8'd50,  8'd50,  8'd50,  1'b1, 1,    1, 1'b0);
    do_meas("w1",   12'd1,   8'd0,   8'd255, 8'd255, 1'b1, 1,    1, 1'b0);
    do_meas("below",12'd5,   8'd51,  8'd60,  8'd50,  1'b0, 5,    1, 1'b0);
    do_meas("above",12'hFFF, 8'd40,  8'd49,  8'd50,  1'b0, 4095, 1, 1'b0);

    // Held start and a start while busy yield a single measurement.
    c0 = ce_cnt; d0 = done_cnt;
    do_meas("hold", 12'd4, 8'd0, 8'd255, 8'd10, 1'b1, 4, 5, 1'b1);
    tick(); tick(); tick();
    chk("hold_busy", busy, 1'b0);
    chk("hold_ce", ce_cnt - c0, 3);
    chk("hold_done", done_cnt - d0, 1);

    // Asynchronous reset inside the gate window.
    window_len = 12'd20; lo_limit = 8'd0; hi_limit = 8'd255; fcounter_eom = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    fcounter_eom = 1'b0;
    tick(); tick(); tick();
    chk("rw_busy", busy, 1'b1);
    #2 rstb = 1'b0;
    #1;
    chk("rw_ctl", {28'd0, fcounter_som, fcounter_ce, busy, done}, 32'd0);
    chk("rw_res", result, 8'd0);
    #2 rstb = 1'b1;
    tick();
    do_meas("post", 12'd7, 8'd70, 8'd80, 8'd77, 1'b1, 7, 1, 1'b0);

    // Not ready: request dropped.
    fcounter_rdy = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nrdy_a", {29'd0, busy, fcounter_ce, fcounter_som}, 32'd0);
    tick(); tick();
    chk("nrdy_b", busy, 1'b0);
    fcounter_rdy = 1'b1;

`ifdef FCOUNTER_SEQ_TIMEOUT_EN
    window_len = 12'd1; fcounter_eom = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    fcounter_eom = 1'b0;
    tick();
    n = 0;
    while (!fcounter_ce && n < 100) begin
      tick();
      n++;
    end
    tick();
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    chk("tmo_cyc", n, 1023);
    chk("tmo_flag", {30'd0, timeout, in_range}, 32'd2);
    chk("tmo_res", result, 8'd77);
    tick();
    do_meas("tmo_clr", 12'd3, 8'd1, 8'd9, 8'd5, 1'b1, 3, 1, 1'b0);
`endif

    chk("ce_b2b", b2b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
